// File: rtl/r5p_trap.sv
// r5p_trap: trap sequencer in front of the R5P CSR block.
// Collects execute-stage exceptions and machine interrupts. At an instruction
// boundary it raises a one-cycle flush and then a one-cycle trap strobe that
// carries cause/epc/tval.
// Optional feature: define R5P_TRAP_IRQ_SYNC_EN to pass each irq_* line
// through a 2-flop synchronizer before mip_o. Level-to-mip_o latency is then
// 3 cycles instead of 1.
module r5p_trap #(
  parameter int unsigned XLEN     = 32,
  parameter bit          IRQ_LOCK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_vld,
  input  logic [4:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            bnd_vld,
  input  logic [XLEN-1:0] bnd_pc,
  input  logic            mret_i,
  input  logic            irq_msi,
  input  logic            irq_mti,
  input  logic            irq_mei,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mie_i,
  output logic [XLEN-1:0] mip_o,
  output logic            flush_o,
  output logic            trap_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] epc_o,
  output logic [XLEN-1:0] tval_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {StIdle, StFlush, StTrap} state_e;

  state_e          state_q, state_d;
  logic [2:0]      irq_lvl;      // {mei, mti, msi}
  logic [2:0]      mip_q;        // {MEIP, MTIP, MSIP}
  logic [2:0]      irq_en;
  logic            irq_lock_q;
  logic            int_req;
  logic [3:0]      irq_code;
  logic            take_exc;
  logic            take_irq;
  logic [XLEN-1:0] irq_cause;
  logic [XLEN-1:0] cap_cause_q, cap_epc_q, cap_tval_q;
  logic [XLEN-1:0] cause_q, epc_q, tval_q;
  logic            unused_mie;

`ifdef R5P_TRAP_IRQ_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous interrupt levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {irq_mei, irq_mti, irq_msi};
      sync2_q <= sync1_q;
    end
  end

  assign irq_lvl = sync2_q;
`else
  assign irq_lvl = {irq_mei, irq_mti, irq_msi};
`endif

  // Pending bits follow the interrupt levels; nothing is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mip_q <= '0;
    end else begin
      mip_q <= irq_lvl;
    end
  end

  // Spread the three pending bits onto their mip positions.
  always_comb begin
    mip_o     = '0;
    mip_o[3]  = mip_q[0];
    mip_o[7]  = mip_q[1];
    mip_o[11] = mip_q[2];
  end

  assign unused_mie = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  assign irq_en  = mip_q & {mie_i[11], mie_i[7], mie_i[3]};
  assign int_req = mstatus_mie & ~irq_lock_q & (|irq_en);

  // Interrupt priority: external, then software, then timer.
  always_comb begin
    irq_code = 4'd7;
    if (irq_en[2]) begin
      irq_code = 4'd11;
    end else if (irq_en[0]) begin
      irq_code = 4'd3;
    end
  end

  always_comb begin
    irq_cause         = '0;
    irq_cause[XLEN-1] = 1'b1;
    irq_cause[3:0]    = irq_code;
  end

  // Events are only accepted in IDLE; exceptions win over interrupts.
  assign take_exc = (state_q == StIdle) & exc_vld;
  assign take_irq = (state_q == StIdle) & ~exc_vld & bnd_vld & int_req;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (take_exc || take_irq) state_d = StFlush;
      StFlush: state_d = StTrap;
      StTrap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    flush_o = 1'b0;
    trap_o  = 1'b0;
    busy_o  = 1'b1;
    unique case (state_q)
      StIdle:  busy_o  = 1'b0;
      StFlush: flush_o = 1'b1;
      StTrap:  trap_o  = 1'b1;
      default: busy_o  = 1'b0;
    endcase
  end

  // Latch the trap details when the event is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cause_q <= '0;
      cap_epc_q   <= '0;
      cap_tval_q  <= '0;
    end else if (take_exc) begin
      cap_cause_q <= XLEN'(exc_code);
      cap_epc_q   <= exc_pc;
      cap_tval_q  <= exc_tval;
    end else if (take_irq) begin
      cap_cause_q <= irq_cause;
      cap_epc_q   <= bnd_pc;
      cap_tval_q  <= '0;
    end
  end

  // Output values only change on entry to TRAP and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
    end else if (state_q == StFlush) begin
      cause_q <= cap_cause_q;
      epc_q   <= cap_epc_q;
      tval_q  <= cap_tval_q;
    end
  end

  assign cause_o = cause_q;
  assign epc_o   = epc_q;
  assign tval_o  = tval_q;

  // Interrupt lock: set by an interrupt trap, cleared by mret in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_lock_q <= 1'b0;
    end else if ((state_q == StIdle) && mret_i) begin
      irq_lock_q <= 1'b0;
    end else if ((state_q == StTrap) && IRQ_LOCK && cap_cause_q[XLEN-1]) begin
      irq_lock_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_r5p_trap.sv
// Directed testbench for r5p_trap with immediate-assertion checks.
module tb_r5p_trap;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            exc_vld;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] exc_pc, exc_tval;
  logic            bnd_vld;
  logic [XLEN-1:0] bnd_pc;
  logic            mret_i;
  logic            irq_msi, irq_mti, irq_mei;
  logic            mstatus_mie;
  logic [XLEN-1:0] mie_i;
  logic [XLEN-1:0] mip_o;
  logic            flush_o, trap_o, busy_o;
  logic [XLEN-1:0] cause_o, epc_o, tval_o;

  int n_assert = 0;
  int n_fail   = 0;

  r5p_trap #(.XLEN(XLEN), .IRQ_LOCK(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exc_vld     (exc_vld),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .exc_tval    (exc_tval),
    .bnd_vld     (bnd_vld),
    .bnd_pc      (bnd_pc),
    .mret_i      (mret_i),
    .irq_msi     (irq_msi),
    .irq_mti     (irq_mti),
    .irq_mei     (irq_mei),
    .mstatus_mie (mstatus_mie),
    .mie_i       (mie_i),
    .mip_o       (mip_o),
    .flush_o     (flush_o),
    .trap_o      (trap_o),
    .cause_o     (cause_o),
    .epc_o       (epc_o),
    .tval_o      (tval_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for mip_o to reach a value; covers both irq latency builds.
  task automatic wait_mip(input string tag, input logic [XLEN-1:0] exp);
    for (int i = 0; i < 6; i++) begin
      if (mip_o === exp) break;
      step();
    end
    check(tag, mip_o, exp);
  endtask

  task automatic mret_pulse();
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; exc_vld = 1'b0; exc_code = '0; exc_pc = '0; exc_tval = '0;
    bnd_vld = 1'b0; bnd_pc = '0; mret_i = 1'b0;
    irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0;
    mstatus_mie = 1'b0; mie_i = '0;
    step(); step();
    check("rst_flush", XLEN'(flush_o), 0);
    check("rst_trap",  XLEN'(trap_o), 0);
    check("rst_busy",  XLEN'(busy_o), 0);
    check("rst_mip",   mip_o, 0);
    check("rst_cause", cause_o, 0);
    rst_n = 1'b1;
    step();

    // Exception: code 2 at 0x80
    exc_vld = 1'b1; exc_code = 5'd2; exc_pc = 32'h80; exc_tval = 32'hDEAD;
    step();
    exc_vld = 1'b0;
    check("exc_flush", XLEN'(flush_o), 1);
    check("exc_busy",  XLEN'(busy_o), 1);
    check("exc_notrap_in_flush", XLEN'(trap_o), 0);
    check("exc_cause_held_in_flush", cause_o, 0);
    step();
    check("exc_trap",  XLEN'(trap_o), 1);
    check("exc_noflush_in_trap", XLEN'(flush_o), 0);
    check("exc_cause", cause_o, 32'h2);
    check("exc_epc",   epc_o, 32'h80);
    check("exc_tval",  tval_o, 32'hDEAD);
    step();
    check("exc_done_busy", XLEN'(busy_o), 0);
    check("exc_done_trap", XLEN'(trap_o), 0);
    check("exc_cause_hold", cause_o, 32'h2);

    // Timer interrupt; a pending interrupt waits for a boundary
    irq_mti = 1'b1; mie_i = 32'h80; mstatus_mie = 1'b1;
    wait_mip("mti_mip", 32'h80);
    step();
    check("mti_wait_no_bnd", XLEN'(busy_o), 0);
    bnd_vld = 1'b1; bnd_pc = 32'h104;
    step();
    bnd_vld = 1'b0;
    check("mti_flush", XLEN'(flush_o), 1);
    step();
    check("mti_trap",  XLEN'(trap_o), 1);
    check("mti_cause", cause_o, 32'h8000_0007);
    check("mti_epc",   epc_o, 32'h104);
    check("mti_tval",  tval_o, 32'h0);
    step();

    // Locked: still pending but no second trap
    bnd_vld = 1'b1; bnd_pc = 32'h108;
    step();
    bnd_vld = 1'b0;
    check("lock_no_flush", XLEN'(flush_o), 0);
    check("lock_no_busy",  XLEN'(busy_o), 0);

    // mret together with an exception: exception taken, lock still cleared
    exc_vld = 1'b1; exc_code = 5'd4; exc_pc = 32'h200; exc_tval = 32'h11; mret_i = 1'b1;
    step();
    exc_vld = 1'b0; mret_i = 1'b0;
    check("mretexc_flush", XLEN'(flush_o), 1);
    step();
    check("mretexc_trap",  XLEN'(trap_o), 1);
    check("mretexc_cause", cause_o, 32'h4);
    check("mretexc_epc",   epc_o, 32'h200);
    step();
    bnd_vld = 1'b1; bnd_pc = 32'h300;
    step();
    bnd_vld = 1'b0;
    check("unlock_flush", XLEN'(flush_o), 1);
    step();
    check("unlock_cause", cause_o, 32'h8000_0007);
    check("unlock_epc",   epc_o, 32'h300);
    step();
    mret_pulse();

    // Priority: all pending, all enabled -> MEI
    irq_mei = 1'b1; irq_msi = 1'b1; mie_i = 32'h888;
    wait_mip("all_mip", 32'h888);
    bnd_vld = 1'b1; bnd_pc = 32'h400;
    step();
    bnd_vld = 1'b0;
    step();
    check("prio_mei_trap",  XLEN'(trap_o), 1);
    check("prio_mei_cause", cause_o, 32'h8000_000B);
    step();
    mret_pulse();

    // MEI masked -> MSI beats MTI
    mie_i = 32'h088;
    bnd_vld = 1'b1; bnd_pc = 32'h500;
    step();
    bnd_vld = 1'b0;
    step();
    check("prio_msi_trap",  XLEN'(trap_o), 1);
    check("prio_msi_cause", cause_o, 32'h8000_0003);
    check("prio_msi_epc",   epc_o, 32'h500);
    step();
    mret_pulse();

    // Global disable -> no trap
    mstatus_mie = 1'b0; mie_i = 32'h888;
    bnd_vld = 1'b1; bnd_pc = 32'h600;
    step();
    check("mie_off_no_flush", XLEN'(flush_o), 0);
    step();
    bnd_vld = 1'b0;
    check("mie_off_no_busy", XLEN'(busy_o), 0);

    // Exception and interrupt in the same cycle; events during FLUSH/TRAP ignored
    mstatus_mie = 1'b1; mie_i = 32'h800;
    exc_vld = 1'b1; exc_code = 5'd11; exc_pc = 32'h700; exc_tval = 32'h0;
    bnd_vld = 1'b1; bnd_pc = 32'h704;
    step();
    check("sim_flush", XLEN'(flush_o), 1);
    exc_code = 5'd5; exc_pc = 32'h800; mret_i = 1'b1;
    step();
    check("sim_trap",  XLEN'(trap_o), 1);
    check("sim_cause", cause_o, 32'hB);
    check("sim_epc",   epc_o, 32'h700);
    exc_vld = 1'b0; bnd_vld = 1'b0; mret_i = 1'b0;
    step();
    check("sim_ignored_busy",  XLEN'(busy_o), 0);
    check("sim_ignored_flush", XLEN'(flush_o), 0);
    check("sim_cause_hold",    cause_o, 32'hB);

    // Asynchronous reset in the middle of FLUSH
    exc_vld = 1'b1; exc_code = 5'd1; exc_pc = 32'h900;
    step();
    exc_vld = 1'b0;
    check("rst2_pre_flush", XLEN'(flush_o), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst2_flush", XLEN'(flush_o), 0);
    check("rst2_trap",  XLEN'(trap_o), 0);
    check("rst2_busy",  XLEN'(busy_o), 0);
    check("rst2_mip",   mip_o, 0);
    check("rst2_cause", cause_o, 0);
    irq_mei = 1'b0; irq_msi = 1'b0; irq_mti = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check("rst2_no_trap_a", XLEN'(trap_o), 0);
    step();
    check("rst2_no_trap_b", XLEN'(trap_o), 0);
    check("rst2_idle", XLEN'(busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
